// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter.
// Holds the FSM state encoding, the default burst length and bus widths,
// and a helper that computes how many low address bits a cache line spans.
package mem_bus_arbiter_pkg;

  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IC_BURST = 2'd1,
    DC_BURST = 2'd2
  } arb_state_e;

  // Number of address bits covered by one cache line (BURST_LEN beats).
  function automatic int line_offset_bits(input int burst_len, input int data_w);
    return $clog2(burst_len * data_w / 8);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the arbiter's client and memory-side signals.
// slave  : arbiter view (takes requests and memory responses, drives grants,
//          beat strobes and the external memory command).
// master : view of the Icache/Dcache/Ctrl clients and the external memory.
// Signals:
//   ic_req/ic_addr -> ic_gnt/ic_rvalid/ic_done/ic_rdata
//   dc_req/dc_we/dc_addr/dc_wdata -> dc_gnt/dc_rvalid/dc_wready/dc_done/dc_rdata
//   csr_memflush
//   mem_req/mem_we/mem_addr/mem_wdata <- mem_ack/mem_rdata
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_gnt;
  logic              ic_rvalid;
  logic              ic_done;
  logic [DATA_W-1:0] ic_rdata;

  logic              dc_req;
  logic              dc_we;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_gnt;
  logic              dc_rvalid;
  logic              dc_wready;
  logic              dc_done;
  logic [DATA_W-1:0] dc_rdata;

  logic              csr_memflush;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ic_req, ic_addr,
    output ic_gnt, ic_rvalid, ic_done, ic_rdata,
    input  dc_req, dc_we, dc_addr, dc_wdata,
    output dc_gnt, dc_rvalid, dc_wready, dc_done, dc_rdata,
    input  csr_memflush,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output ic_req, ic_addr,
    input  ic_gnt, ic_rvalid, ic_done, ic_rdata,
    output dc_req, dc_we, dc_addr, dc_wdata,
    input  dc_gnt, dc_rvalid, dc_wready, dc_done, dc_rdata,
    output csr_memflush,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin decision.
// Ports: req0, req1 (requests), ptr (0 favours req0, 1 favours req1),
//        gnt0, gnt1 (one-hot or zero decision, purely combinational).
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic gnt0,
  output logic gnt1
);

  // A lone requester always wins; on contention ptr picks the owner.
  assign gnt0 = req0 & (~req1 | ~ptr);
  assign gnt1 = req1 & (~req0 |  ptr);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the Icache (refill only) and Dcache (refill or writeback)
// onto a single burst-oriented external memory port.
// Ports:
//   clk   - sole clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - client and memory signals (slave view of mem_bus_arbiter_if)
// Each grant runs one BURST_LEN-beat line transfer; the memory acks one
// beat per asserted cycle. At least one IDLE cycle separates bursts.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input logic              clk,
  input logic              rst_n,
  mem_bus_arbiter_if.slave bus
);

  localparam int BEAT_W  = $clog2(BURST_LEN);
  localparam int OFS_W   = line_offset_bits(BURST_LEN, DATA_W);
  localparam int BYTE_SH = $clog2(DATA_W / 8);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~((ADDR_W'(1) << OFS_W) - ADDR_W'(1));

  arb_state_e        state_q, state_d;
  logic              rr_ptr_q;
  logic [BEAT_W-1:0] beat_q;
  logic [ADDR_W-1:0] base_q;
  logic              we_q;
  logic              ic_gnt_q, dc_gnt_q;

  logic              dc_req_eff;
  logic              arb_dc, arb_ic;
  logic              grant_dc, grant_ic;
  logic              last_beat;
  logic [ADDR_W-1:0] beat_addr;

  logic              ic_rvalid, ic_done;
  logic [DATA_W-1:0] ic_rdata;
  logic              dc_rvalid, dc_wready, dc_done;
  logic [DATA_W-1:0] dc_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // A pending flush holds off new Dcache ownership but not the Icache.
  assign dc_req_eff = bus.dc_req & ~bus.csr_memflush;

  rr_arb2 u_rr_arb2 (
    .req0 (dc_req_eff),
    .req1 (bus.ic_req),
    .ptr  (rr_ptr_q),
    .gnt0 (arb_dc),
    .gnt1 (arb_ic)
  );

  assign last_beat = (beat_q == LAST_BEAT);
  assign beat_addr = base_q + (ADDR_W'(beat_q) << BYTE_SH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    grant_dc  = 1'b0;
    grant_ic  = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ic_rvalid = 1'b0;
    ic_done   = 1'b0;
    ic_rdata  = '0;
    dc_rvalid = 1'b0;
    dc_wready = 1'b0;
    dc_done   = 1'b0;
    dc_rdata  = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_dc) begin
          grant_dc = 1'b1;
          state_d  = DC_BURST;
        end else if (arb_ic) begin
          grant_ic = 1'b1;
          state_d  = IC_BURST;
        end
      end
      IC_BURST: begin
        mem_req   = 1'b1;
        mem_addr  = beat_addr;
        ic_rvalid = bus.mem_ack;
        ic_rdata  = bus.mem_rdata;
        ic_done   = bus.mem_ack & last_beat;
        if (ic_done) state_d = IDLE;
      end
      DC_BURST: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = beat_addr;
        mem_wdata = we_q ? bus.dc_wdata : '0;
        dc_rvalid = bus.mem_ack & ~we_q;
        dc_rdata  = we_q ? '0 : bus.mem_rdata;
        dc_wready = bus.mem_ack & we_q;
        dc_done   = bus.mem_ack & last_beat;
        if (dc_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant bookkeeping: latch line base and direction, restart the beat
  // count, and hand priority to the requester that just lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
      beat_q   <= '0;
      base_q   <= '0;
      we_q     <= 1'b0;
      ic_gnt_q <= 1'b0;
      dc_gnt_q <= 1'b0;
    end else begin
      ic_gnt_q <= grant_ic;
      dc_gnt_q <= grant_dc;
      if (grant_dc) begin
        rr_ptr_q <= 1'b1;
        base_q   <= bus.dc_addr & LINE_MASK;
        we_q     <= bus.dc_we;
        beat_q   <= '0;
      end else if (grant_ic) begin
        rr_ptr_q <= 1'b0;
        base_q   <= bus.ic_addr & LINE_MASK;
        we_q     <= 1'b0;
        beat_q   <= '0;
      end else if (state_q != IDLE && bus.mem_ack) begin
        beat_q   <= beat_q + BEAT_W'(1);
      end
    end
  end

  assign bus.ic_gnt    = ic_gnt_q;
  assign bus.ic_rvalid = ic_rvalid;
  assign bus.ic_done   = ic_done;
  assign bus.ic_rdata  = ic_rdata;
  assign bus.dc_gnt    = dc_gnt_q;
  assign bus.dc_rvalid = dc_rvalid;
  assign bus.dc_wready = dc_wready;
  assign bus.dc_done   = dc_done;
  assign bus.dc_rdata  = dc_rdata;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;

endmodule
